// File: rtl/load_router_pkg.sv
// Shared types and load-mode encodings for the banked load-data router.
package load_router_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_IFM, LOAD_W1, LOAD_W2, FIN} ld_state_t;

  localparam logic [1:0] NO_LOAD       = 2'd0;
  localparam logic [1:0] LOAD_IFM_C    = 2'd1;
  localparam logic [1:0] LOAD_WEIGHT_C = 2'd2;
endpackage

// File: rtl/load_data_router_banked_interleaver.sv
// Maps a region-local word count onto a modulo-interleaved bank: one-hot we, row address, overflow.
module bank_interleaver #(
  parameter int B       = 4,
  parameter int BANK_AW = 16,
  parameter int ADDR_W  = 32
) (
  input  logic [ADDR_W-1:0]  n,
  output logic [B-1:0]       we,
  output logic [BANK_AW-1:0] addr,
  output logic               ovf
);
  localparam int LB = (B > 1) ? $clog2(B) : 0;

  logic [ADDR_W-1:0] row;

  assign row  = n >> LB;
  assign addr = row[BANK_AW-1:0];

  generate
    if (B > 1) begin : g_multi
      assign we = B'(1) << n[LB-1:0];
    end else begin : g_single
      assign we = 1'b1;
    end
    // Any row bit beyond the bank depth means the region outgrew its banks.
    if (ADDR_W > BANK_AW) begin : g_ovf
      assign ovf = |row[ADDR_W-1:BANK_AW];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/load_data_router_banked.sv
// Steers a fused load stream into IFM / layer-1 / layer-2 weight banks with internal addressing.
module load_data_router_banked
  import load_router_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int IFM_BANKS = 4,
  parameter int L1_BANKS  = 16,
  parameter int L2_BANKS  = 4,
  parameter int BANK_AW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           control_load,
  input  logic [ADDR_W-1:0]    size_ifm,
  input  logic [ADDR_W-1:0]    size_w_l1,
  input  logic [ADDR_W-1:0]    size_w_l2,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [IFM_BANKS-1:0] ifm_we,
  output logic [BANK_AW-1:0]   ifm_addr,
  output logic [DATA_W-1:0]    ifm_wdata,
  output logic [L1_BANKS-1:0]  w1_we,
  output logic [BANK_AW-1:0]   w1_addr,
  output logic [DATA_W-1:0]    w1_wdata,
  output logic [L2_BANKS-1:0]  w2_we,
  output logic [BANK_AW-1:0]   w2_addr,
  output logic [DATA_W-1:0]    w2_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  ld_state_t state, state_nx;

  logic [ADDR_W-1:0] cnt, sz_ifm, sz_w1, sz_w2, sz_cur;
  logic              accept, last;

  logic [IFM_BANKS-1:0] we_ifm;
  logic [L1_BANKS-1:0]  we_w1;
  logic [L2_BANKS-1:0]  we_w2;
  logic [BANK_AW-1:0]   a_ifm, a_w1, a_w2;
  logic                 ovf_ifm, ovf_w1, ovf_w2;

  assign in_ready = (state == LOAD_IFM) || (state == LOAD_W1) || (state == LOAD_W2);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    sz_cur = '0;
    case (state)
      LOAD_IFM: sz_cur = sz_ifm;
      LOAD_W1:  sz_cur = sz_w1;
      LOAD_W2:  sz_cur = sz_w2;
      default:  sz_cur = '0;
    endcase
  end

  assign last = (cnt == sz_cur - ADDR_W'(1));

  // One shared counter is enough: it restarts at 0 on every region switch.
  bank_interleaver #(.B(IFM_BANKS), .BANK_AW(BANK_AW), .ADDR_W(ADDR_W)) u_il_ifm (
    .n(cnt), .we(we_ifm), .addr(a_ifm), .ovf(ovf_ifm));
  bank_interleaver #(.B(L1_BANKS), .BANK_AW(BANK_AW), .ADDR_W(ADDR_W)) u_il_w1 (
    .n(cnt), .we(we_w1), .addr(a_w1), .ovf(ovf_w1));
  bank_interleaver #(.B(L2_BANKS), .BANK_AW(BANK_AW), .ADDR_W(ADDR_W)) u_il_w2 (
    .n(cnt), .we(we_w2), .addr(a_w2), .ovf(ovf_w2));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          case (control_load)
            LOAD_IFM_C:    state_nx = (size_ifm != '0) ? LOAD_IFM : FIN;
            LOAD_WEIGHT_C: state_nx = (size_w_l1 != '0) ? LOAD_W1 :
                                      (size_w_l2 != '0) ? LOAD_W2 : FIN;
            default:       state_nx = IDLE;
          endcase
        end
      end
      LOAD_IFM: if (accept && last) state_nx = FIN;
      LOAD_W1:  if (accept && last) state_nx = (sz_w2 != '0) ? LOAD_W2 : FIN;
      LOAD_W2:  if (accept && last) state_nx = FIN;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sz_ifm    <= '0;
      sz_w1     <= '0;
      sz_w2     <= '0;
      ifm_we    <= '0;
      ifm_addr  <= '0;
      ifm_wdata <= '0;
      w1_we     <= '0;
      w1_addr   <= '0;
      w1_wdata  <= '0;
      w2_we     <= '0;
      w2_addr   <= '0;
      w2_wdata  <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state  <= state_nx;
      done   <= (state == FIN);
      ifm_we <= '0;
      w1_we  <= '0;
      w2_we  <= '0;
      if (state == IDLE && start) begin
        sz_ifm   <= size_ifm;
        sz_w1    <= size_w_l1;
        sz_w2    <= size_w_l2;
        cnt      <= '0;
        overflow <= 1'b0;
      end
      if (accept) begin
        cnt <= last ? '0 : cnt + ADDR_W'(1);
        case (state)
          LOAD_IFM: begin
            ifm_we    <= we_ifm;
            ifm_addr  <= a_ifm;
            ifm_wdata <= in_data;
            if (ovf_ifm) overflow <= 1'b1;
          end
          LOAD_W1: begin
            w1_we    <= we_w1;
            w1_addr  <= a_w1;
            w1_wdata <= in_data;
            if (ovf_w1) overflow <= 1'b1;
          end
          LOAD_W2: begin
            w2_we    <= we_w2;
            w2_addr  <= a_w2;
            w2_wdata <= in_data;
            if (ovf_w2) overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_load_data_router_banked.sv
// Directed bench: two routers (full depth and 2-bit bank address) share one stimulus, scoreboarded writes.
`timescale 1ns/1ps
module tb_load_data_router_banked;
  localparam int DW = 32, AW = 32, IB = 4, L1B = 16, L2B = 4, BAW = 16, SAW = 2;

  logic           clk = 1'b0;
  logic           reset, start, in_valid;
  logic [1:0]     control_load;
  logic [AW-1:0]  size_ifm, size_w_l1, size_w_l2;
  logic [DW-1:0]  in_data;

  logic           in_ready, busy, done, overflow;
  logic [IB-1:0]  ifm_we;   logic [BAW-1:0] ifm_addr; logic [DW-1:0] ifm_wdata;
  logic [L1B-1:0] w1_we;    logic [BAW-1:0] w1_addr;  logic [DW-1:0] w1_wdata;
  logic [L2B-1:0] w2_we;    logic [BAW-1:0] w2_addr;  logic [DW-1:0] w2_wdata;

  logic           in_ready_s, busy_s, done_s, overflow_s;
  logic [IB-1:0]  ifm_we_s; logic [SAW-1:0] ifm_addr_s; logic [DW-1:0] ifm_wdata_s;
  logic [L1B-1:0] w1_we_s;  logic [SAW-1:0] w1_addr_s;  logic [DW-1:0] w1_wdata_s;
  logic [L2B-1:0] w2_we_s;  logic [SAW-1:0] w2_addr_s;  logic [DW-1:0] w2_wdata_s;

  always #5 clk = ~clk;

  load_data_router_banked #(.DATA_W(DW), .ADDR_W(AW), .IFM_BANKS(IB), .L1_BANKS(L1B),
    .L2_BANKS(L2B), .BANK_AW(BAW)) dut (
    .clk(clk), .reset(reset), .start(start), .control_load(control_load),
    .size_ifm(size_ifm), .size_w_l1(size_w_l1), .size_w_l2(size_w_l2),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ifm_we(ifm_we), .ifm_addr(ifm_addr), .ifm_wdata(ifm_wdata),
    .w1_we(w1_we), .w1_addr(w1_addr), .w1_wdata(w1_wdata),
    .w2_we(w2_we), .w2_addr(w2_addr), .w2_wdata(w2_wdata),
    .busy(busy), .done(done), .overflow(overflow));

  load_data_router_banked #(.DATA_W(DW), .ADDR_W(AW), .IFM_BANKS(IB), .L1_BANKS(L1B),
    .L2_BANKS(L2B), .BANK_AW(SAW)) dut_s (
    .clk(clk), .reset(reset), .start(start), .control_load(control_load),
    .size_ifm(size_ifm), .size_w_l1(size_w_l1), .size_w_l2(size_w_l2),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .ifm_we(ifm_we_s), .ifm_addr(ifm_addr_s), .ifm_wdata(ifm_wdata_s),
    .w1_we(w1_we_s), .w1_addr(w1_addr_s), .w1_wdata(w1_wdata_s),
    .w2_we(w2_we_s), .w2_addr(w2_addr_s), .w2_wdata(w2_wdata_s),
    .busy(busy_s), .done(done_s), .overflow(overflow_s));

  typedef struct {
    int          rg;
    logic [15:0] we;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q_m[$], q_s[$];
  int checks = 0, errors = 0, wseq = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbanks(input int rg);
    return (rg == 1) ? L1B : (rg == 2) ? L2B : IB;
  endfunction

  function automatic exp_t mk(input int rg, input int n, input int aw, input logic [31:0] d);
    exp_t e;
    e.rg   = rg;
    e.we   = 16'(1) << (n % nbanks(rg));
    e.addr = 16'((n / nbanks(rg)) % (1 << aw));
    e.data = d;
    return e;
  endfunction

  // Write monitors: every non-zero we must match the head of that router's scoreboard.
  always @(negedge clk) begin : mon_m
    exp_t o, e;
    int nz;
    nz = int'(ifm_we != 0) + int'(w1_we != 0) + int'(w2_we != 0);
    if (nz > 1) chk("m_multi_region", 64'(nz), 64'd1);
    if (nz != 0) begin
      o.rg   = (ifm_we != 0) ? 0 : (w1_we != 0) ? 1 : 2;
      o.we   = (o.rg == 0) ? 16'(ifm_we)   : (o.rg == 1) ? 16'(w1_we)   : 16'(w2_we);
      o.addr = (o.rg == 0) ? ifm_addr      : (o.rg == 1) ? w1_addr      : w2_addr;
      o.data = (o.rg == 0) ? ifm_wdata     : (o.rg == 1) ? w1_wdata     : w2_wdata;
      if (q_m.size() == 0) chk("m_unexpected_write", 64'(o.we), 64'd0);
      else begin
        e = q_m.pop_front();
        chk("m_region", 64'(o.rg), 64'(e.rg));
        chk("m_we", 64'(o.we), 64'(e.we));
        chk("m_addr", 64'(o.addr), 64'(e.addr));
        chk("m_wdata", 64'(o.data), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_s
    exp_t o, e;
    int nz;
    nz = int'(ifm_we_s != 0) + int'(w1_we_s != 0) + int'(w2_we_s != 0);
    if (nz > 1) chk("s_multi_region", 64'(nz), 64'd1);
    if (nz != 0) begin
      o.rg   = (ifm_we_s != 0) ? 0 : (w1_we_s != 0) ? 1 : 2;
      o.we   = (o.rg == 0) ? 16'(ifm_we_s)   : (o.rg == 1) ? 16'(w1_we_s)   : 16'(w2_we_s);
      o.addr = (o.rg == 0) ? 16'(ifm_addr_s) : (o.rg == 1) ? 16'(w1_addr_s) : 16'(w2_addr_s);
      o.data = (o.rg == 0) ? ifm_wdata_s     : (o.rg == 1) ? w1_wdata_s     : w2_wdata_s;
      if (q_s.size() == 0) chk("s_unexpected_write", 64'(o.we), 64'd0);
      else begin
        e = q_s.pop_front();
        chk("s_region", 64'(o.rg), 64'(e.rg));
        chk("s_we", 64'(o.we), 64'(e.we));
        chk("s_addr", 64'(o.addr), 64'(e.addr));
        chk("s_wdata", 64'(o.data), 64'(e.data));
      end
    end
  end

  // All drivers run from posedge+1; each task returns at posedge+1.
  task automatic do_start(input logic [1:0] mode, input int s0, input int s1, input int s2);
    control_load = mode;
    size_ifm     = AW'(s0);
    size_w_l1    = AW'(s1);
    size_w_l2    = AW'(s2);
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic stream(input logic [1:0] mode, input int s0, input int s1, input int s2,
                        input bit toggle, input int stop_at);
    int total, idx, cyc, rg, n;
    bit acc;
    total = (mode == 2'd1) ? s0 : (mode == 2'd2) ? s1 + s2 : 0;
    idx = 0;
    cyc = 0;
    while (idx < total && idx < stop_at && cyc < 500) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = 32'hA500_0000 + 32'(wseq);
      @(negedge clk);
      chk("in_ready_mid_load", 64'(in_ready), 64'd1);
      chk("busy_mid_load", 64'(busy), 64'd1);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        if (mode == 2'd1)   begin rg = 0; n = idx;      end
        else if (idx < s1)  begin rg = 1; n = idx;      end
        else                begin rg = 2; n = idx - s1; end
        q_m.push_back(mk(rg, n, BAW, in_data));
        q_s.push_back(mk(rg, n, SAW, in_data));
        idx++;
        wseq++;
      end
      #1;
      cyc++;
    end
    if (idx < total && idx < stop_at) chk("stream_timeout", 64'(idx), 64'(total));
    in_valid = 1'b0;
  endtask

  task automatic chk_done(input string tag);
    @(negedge clk);
    chk({tag, "_done_early"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_s"}, 64'(done_s), 64'd1);
    chk({tag, "_sb_drained"}, 64'(q_m.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_done_clear"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [1:0] mode, input int s0, input int s1, input int s2,
                      input bit toggle, input string tag);
    do_start(mode, s0, s1, s2);
    stream(mode, s0, s1, s2, toggle, 1 << 30);
    chk_done(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 64'({ifm_we, w1_we, w2_we}), 64'd0);
    chk({tag, "_addr"}, 64'({ifm_addr, w1_addr, w2_addr}), 64'd0);
    chk({tag, "_wdata"}, {32'(ifm_wdata | w1_wdata), w2_wdata}, 64'd0);
    chk({tag, "_flags"}, 64'({in_ready, busy, done, overflow}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    control_load = 2'd0; size_ifm = '0; size_w_l1 = '0; size_w_l2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Valid while idle is neither accepted nor written
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    load(2'd1, 6, 0, 0, 1'b0, "t1_ifm6");
    load(2'd2, 0, 18, 5, 1'b0, "t2_w18_5");
    chk("t2_no_ovf_s", 64'(overflow_s), 64'd0);
    load(2'd2, 0, 0, 3, 1'b1, "t3_w2only");
    load(2'd1, 0, 0, 0, 1'b0, "t4_zero");

    // Reserved / no-load modes never leave IDLE
    do_start(2'd0, 5, 5, 5);
    repeat (3) begin
      @(negedge clk);
      chk("t4_mode0_flags", 64'({busy, done}), 64'd0);
    end
    @(posedge clk); #1;
    do_start(2'd3, 5, 5, 5);
    repeat (3) begin
      @(negedge clk);
      chk("t4_mode3_flags", 64'({busy, done}), 64'd0);
    end
    @(posedge clk); #1;

    // T5: second start while busy is ignored; reset mid W1 drops the pending write
    do_start(2'd2, 0, 20, 4);
    do_start(2'd1, 3, 0, 0);
    stream(2'd2, 0, 20, 4, 1'b0, 7);
    reset    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("t5_reset");
    chk("t5_sb_empty", 64'(q_m.size()), 64'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_done", 64'({busy, done}), 64'd0);
    end
    @(posedge clk); #1;
    load(2'd2, 0, 3, 2, 1'b0, "t5_restart");

    // T6: 17 IFM words over 4 banks of depth 4 -> word 16 overflows and wraps to addr 0
    load(2'd1, 17, 0, 0, 1'b0, "t6_ovf");
    chk("t6_overflow_s", 64'(overflow_s), 64'd1);
    chk("t6_overflow_main", 64'(overflow), 64'd0);
    do_start(2'd1, 1, 0, 0);
    @(negedge clk);
    chk("t6_ovf_cleared", 64'(overflow_s), 64'd0);
    @(posedge clk); #1;
    stream(2'd1, 1, 0, 0, 1'b0, 1 << 30);
    @(negedge clk);
    @(negedge clk);
    chk("t6_short_done", 64'(done_s), 64'd1);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    chk("end_sb_m", 64'(q_m.size()), 64'd0);
    chk("end_sb_s", 64'(q_s.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
